// File: rtl/btc_host_pkg.sv
// Shared types and constants for the SHA256d tile host controller.
package btc_host_pkg;

   localparam int unsigned HASH_BYTES = 32;
   localparam int unsigned WORD_COUNT = 32;
   localparam int unsigned WORD_AW    = 5;
   localparam int unsigned K_W        = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FEED  = 2'd1,
      ST_READ  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   // Byte 0 of a message word is its most significant byte.
   function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/btc_hs_responder.sv
// rq/rdy handshake responder with idle timeout for the mining tile.
// BTC_HOST_SYNC_EN adds two-flop synchronizers on chip_rq and chip_done.
module btc_hs_responder #(
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic clk,
   input  logic rst,
   input  logic serve_en,
   input  logic count_en,
   input  logic clr,
   input  logic chip_rq,
   input  logic chip_done,
   output logic chip_rdy,
   output logic serve_c,
   output logic expired_c,
   output logic done_c
);

   localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   logic             rq_c;
   logic             armed_q;
   logic [CNT_W-1:0] cnt_q;

`ifdef BTC_HOST_SYNC_EN
   logic [1:0] rq_sync;
   logic [1:0] done_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         rq_sync   <= '0;
         done_sync <= '0;
      end else begin
         rq_sync   <= {rq_sync[0], chip_rq};
         done_sync <= {done_sync[0], chip_done};
      end
   end

   assign rq_c   = rq_sync[1];
   assign done_c = done_sync[1];
`else
   assign rq_c   = chip_rq;
   assign done_c = chip_done;
`endif

   // Abort wins over a serve landing on the same edge, so rdy stays low.
   assign expired_c = count_en && (cnt_q == CNT_W'(TIMEOUT - 1));
   assign serve_c   = serve_en && rq_c && armed_q && !expired_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         armed_q  <= 1'b1;
         chip_rdy <= 1'b0;
         cnt_q    <= '0;
      end else begin
         chip_rdy <= serve_c;
         if (serve_c)
            armed_q <= 1'b0;
         else if (!rq_c)
            armed_q <= 1'b1;
         if (clr || serve_c || !count_en)
            cnt_q <= '0;
         else
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/btc_host_ctrl.sv
// Host controller for the SHA256d tile: word store, feed/readout FSM, digest register.
// Optional BTC_HOST_SYNC_EN synchronizes chip_rq/chip_done inside the responder.
module btc_host_ctrl
   import btc_host_pkg::*;
#(
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_we,
   input  logic [WORD_AW-1:0]      cfg_addr,
   input  logic [31:0]             cfg_wdata,
   input  logic                    go,
   output logic                    busy,
   output logic                    hash_valid,
   output logic [8*HASH_BYTES-1:0] hash,
   output logic                    timeout,
   output logic                    chip_start,
   output logic                    chip_rdy,
   output logic [7:0]              chip_data,
   input  logic                    chip_rq,
   input  logic                    chip_done,
   input  logic [7:0]              chip_uo
);

   logic [31:0] word_mem [WORD_COUNT];

   state_t                  state_q, state_d;
   logic [K_W-1:0]          k_q, k_d;
   logic [8*HASH_BYTES-1:0] hash_d;
   logic [7:0]              chip_data_d;
   logic                    busy_d, hash_valid_d, timeout_d, chip_start_d;

   logic serve_c, expired_c, done_c;
   logic serve_en_c, count_en_c, clr_c;

   // Store is writable only between runs.
   always_ff @(posedge clk) begin
      if (cfg_we && !busy)
         word_mem[cfg_addr] <= cfg_wdata;
   end

   assign serve_en_c = ((state_q == ST_FEED) && !done_c) || (state_q == ST_READ);
   assign count_en_c = (state_q != ST_IDLE);
   assign clr_c      = (state_d != state_q);

   btc_hs_responder #(
      .TIMEOUT (TIMEOUT)
   ) u_resp (
      .clk       (clk),
      .rst       (rst),
      .serve_en  (serve_en_c),
      .count_en  (count_en_c),
      .clr       (clr_c),
      .chip_rq   (chip_rq),
      .chip_done (chip_done),
      .chip_rdy  (chip_rdy),
      .serve_c   (serve_c),
      .expired_c (expired_c),
      .done_c    (done_c)
   );

   always_comb begin
      state_d      = state_q;
      k_d          = k_q;
      hash_d       = hash;
      chip_data_d  = chip_data;
      busy_d       = busy;
      hash_valid_d = hash_valid;
      timeout_d    = timeout;
      chip_start_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (go) begin
               state_d      = ST_FEED;
               chip_start_d = 1'b1;
               busy_d       = 1'b1;
               hash_valid_d = 1'b0;
               timeout_d    = 1'b0;
               k_d          = '0;
            end
         end
         ST_FEED: begin
            // During feed chip_uo carries {0, word addr, byte idx}.
            if (done_c)
               state_d = ST_READ;
            else if (serve_c)
               chip_data_d = byte_lane(word_mem[chip_uo[6:2]], chip_uo[1:0]);
         end
         ST_READ: begin
            if (serve_c) begin
               hash_d[{~k_q[4:0], 3'b000} +: 8] = chip_uo;
               k_d = k_q + K_W'(1);
               if (k_q == K_W'(HASH_BYTES - 1))
                  state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!done_c) begin
               state_d      = ST_IDLE;
               busy_d       = 1'b0;
               hash_valid_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (expired_c) begin
         state_d      = ST_IDLE;
         busy_d       = 1'b0;
         hash_valid_d = 1'b0;
         timeout_d    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         k_q        <= '0;
         hash       <= '0;
         chip_data  <= 8'h00;
         busy       <= 1'b0;
         hash_valid <= 1'b0;
         timeout    <= 1'b0;
         chip_start <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         hash       <= hash_d;
         chip_data  <= chip_data_d;
         busy       <= busy_d;
         hash_valid <= hash_valid_d;
         timeout    <= timeout_d;
         chip_start <= chip_start_d;
      end
   end

endmodule

// File: doc/btc_host_ctrl.md
# btc_host_ctrl

Host-side controller for the SHA256d mining tile. It stores the message words, pulses the tile's start line, and serves each byte request on the tile's rq/rdy handshake. It then collects the 32 hash bytes the tile streams back and presents the full 256-bit digest to the surrounding host logic, either FPGA fabric or a test harness.

## Interface
- Parameters:
  - `TIMEOUT`, default 65535: idle cycles allowed in FEED/READ before abort.
- Ports (clock and reset first):
  - `clk` in 1: the single clock. All logic is on its rising edge.
  - `rst` in 1: synchronous, active-high reset.
  - `cfg_we` in 1: word-store write strobe.
  - `cfg_addr` in 5: word index, 0..31.
  - `cfg_wdata` in 32: message word. Byte 0 is bits [31:24].
  - `go` in 1: request a hash run.
  - `busy` out 1: a run is in progress.
  - `hash_valid` out 1: `hash` holds a completed digest.
  - `hash` out 256: digest. Byte k sits in [255-8k -: 8].
  - `timeout` out 1: the last run was aborted. Sticky.
  - `chip_start` out 1: to the tile's start input.
  - `chip_rdy` out 1: to the tile's rdy input.
  - `chip_data` out 8: to the tile's dedicated data inputs.
  - `chip_rq` in 1: the tile's request output.
  - `chip_done` in 1: the tile's done output.
  - `chip_uo` in 8: the tile's dedicated outputs.
    - During feed: {0, word addr[4:0], byte idx[1:0]}.
    - During readout: hash byte.

## Operation
- Word store: 32 x 32 bits, not reset.
  - Writes are accepted only when `busy`=0. Writes while busy are dropped.
- State machine states: IDLE, FEED, READ, DRAIN.
  - **IDLE**: on `go`, go to FEED.
    - Set `chip_start`=1 for exactly one cycle, `busy`=1, `hash_valid`=0, `timeout`=0.
    - Clear the readout byte counter k.
    - `go` while busy is ignored.
  - **FEED**: handshake responder serves data requests.
    - At the edge where rdy is raised, decode addr=`chip_uo[6:2]` and idx=`chip_uo[1:0]`.
    - Register `chip_data` = word[addr][31-8*idx -: 8].
    - `chip_data` holds until the next serve.
    - Sampled `chip_done`=1 moves to READ, taking priority over a pending serve.
  - **READ**: at each rdy-raise edge, capture `chip_uo` into hash byte k, then k=k+1.
    - After k reaches 32, go to DRAIN.
  - **DRAIN**: wait for sampled `chip_done`=0, then go to IDLE with `busy`=0 and `hash_valid`=1.
- Handshake rule, identical in FEED and READ:
  - `chip_rdy` is a registered one-cycle pulse, raised when sampled rq=1 and the responder is armed.
  - The pulse disarms the responder.
  - The responder re-arms only after it samples rq=0.
  - rdy is never high for two consecutive cycles.
- Timeout counter:
  - Cleared on every rdy pulse and every state change.
  - Counts in FEED/READ/DRAIN.
  - On reaching `TIMEOUT`: set `timeout`=1, drop to IDLE, `busy`=0, `hash_valid`=0, `chip_rdy`=0.

## Timing
- Reset values:
  - `busy`, `hash_valid`, `timeout`, `chip_start`, `chip_rdy` = 0.
  - `chip_data` = 0x00.
  - `hash` = 0.
  - State = IDLE.
- `go` sampled at edge N: `chip_start`=1 during cycle N+1, low from N+2.
- Sampled rq=1 at edge T: `chip_rdy`=1 and `chip_data` valid in cycle T+1, rdy low in T+2.
- With the tile's re-request gap, one byte completes every 3 cycles (no sync).
- `hash_valid` rises 1 cycle after sampled `chip_done`=0 in DRAIN.
- `rst` mid-run:
  - Immediate return to IDLE with all reset values.
  - The tile must be reset alongside.

## Configuration
- `BTC_HOST_SYNC_EN` defined:
  - `chip_rq` and `chip_done` pass through two-flop synchronizers before all use.
  - Sampled-signal latency rises by 2 cycles, giving 5 cycles per byte.
  - `chip_uo` is still sampled directly, since it is stable while rq has been high for two or more cycles.
- Undefined: `chip_rq` and `chip_done` are used directly (same clock domain).

## Structure
- Package `btc_host_pkg`:
  - State enum.
  - `HASH_BYTES`=32, `WORD_COUNT`=32.
  - Byte-lane select function (word, idx) -> byte.
- Sub-module `btc_hs_responder`:
  - Optional synchronizers, arm flag, rdy pulse, timeout counter.
  - Outputs `serve` (the rdy-raise strobe) and `expired`.
- The top holds the word store, FSM, and hash register.

## Test plan
- Load words 0..19 with 0x00010203 + 0x04040404*n, pulse `go`, tile model requests (addr 2, idx 1) → `chip_data`=0x09 with one-cycle `chip_rdy` 1 cycle after rq.
- Tile model streams hash bytes 0x00..0x1F → `hash`=0x000102…1F, `hash_valid`=1 only after done falls, `busy`=0.
- Model holds rq high for 10 cycles → exactly one rdy pulse; rdy re-pulses only after rq low, then high again.
- `TIMEOUT`=16, model never raises rq → `timeout`=1 at 16 idle cycles, `busy`=0; next `go` clears `timeout`.
- `rst` asserted mid-READ at k=7 → all outputs at reset values next cycle. `cfg_we` while busy → store unchanged on next run.
- `BTC_HOST_SYNC_EN` build repeats scenario 2 → same digest, 5-cycle byte cadence.
